// File: rtl/shared_or_arbiter.sv
// Round-robin arbiter feeding one shared WIDTH-bit OR unit into a single
// result register with valid/ready handshake and a consumed-result counter.

module shared_or_arbiter_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           gnt_en,
  input  logic [IDW-1:0] gnt_idx,
  output logic           ready
);
  assign ready = gnt_en && (gnt_idx == IDW'(LANE));
endmodule

module shared_or_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 2,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESET,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_or,
  output logic [WIDTH-1:0]       out_inv,
  output logic [IDW-1:0]         out_id,
  output logic [7:0]             done_count
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                        state, state_nxt;
  logic [IDW-1:0]                last_grant, gnt_idx, hi_idx, lo_idx;
  logic                          hi_found, lo_found, gnt_en, slot_free, xfer;
  logic [N_REQ-1:0][WIDTH-1:0]   a_v, b_v;
  logic [WIDTH-1:0]              or_res;

  assign a_v       = req_a;
  assign b_v       = req_b;
  assign out_valid = (state == FULL);
  assign slot_free = !out_valid || out_ready;
  assign out_inv   = ~out_or;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) begin
        if (i > int'(last_grant)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IDW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDW'(i);
        end
      end
    end
  end

  assign gnt_idx = hi_found ? hi_idx : lo_idx;
  assign gnt_en  = !ASYNCRESET && slot_free && (hi_found || lo_found);

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_lane
      shared_or_arbiter_lane #(.IDW(IDW), .LANE(g)) u_lane (
        .gnt_en  (gnt_en),
        .gnt_idx (gnt_idx),
        .ready   (req_ready[g])
      );
    end
  endgenerate

  assign xfer   = |(req_valid & req_ready);
  assign or_res = a_v[gnt_idx] | b_v[gnt_idx];

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (xfer) state_nxt = FULL;
      FULL:    if (out_ready && !xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) state <= EMPTY;
    else            state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      out_or     <= '0;
      out_id     <= '0;
      last_grant <= IDW'(N_REQ - 1);
      done_count <= '0;
    end else begin
      if (xfer) begin
        out_or     <= or_res;
        out_id     <= gnt_idx;
        last_grant <= gnt_idx;
      end
      if (out_valid && out_ready) done_count <= done_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_shared_or_arbiter.sv
// Scoreboard bench: expected results queued at grant time, compared on consume.

module tb_shared_or_arbiter;
  localparam int N   = 4;
  localparam int W   = 2;
  localparam int IDW = 2;

  logic                CLK = 1'b0;
  logic                ASYNCRESET;
  logic [N-1:0]        req_valid;
  logic [N*W-1:0]      req_a, req_b;
  logic [N-1:0]        req_ready;
  logic                out_valid, out_ready;
  logic [W-1:0]        out_or, out_inv;
  logic [IDW-1:0]      out_id;
  logic [7:0]          done_count;

  shared_or_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_or     (out_or),
    .out_inv    (out_inv),
    .out_id     (out_id),
    .done_count (done_count)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W+IDW-1:0] sb[$];
  logic             m_valid;
  int               m_last;
  logic [7:0]       m_cnt;
  int               last_gi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check at negedge against the model, advance the model, return at posedge+1.
  task automatic step();
    logic [N-1:0]     er;
    logic [W-1:0]     inv_exp;
    logic [W+IDW-1:0] e;
    logic [W-1:0]     o;
    int               gi, j;
    @(negedge CLK);
    er = '0;
    gi = -1;
    if (!m_valid || out_ready)
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (gi < 0 && req_valid[j]) gi = j;
      end
    if (gi >= 0) er[gi] = 1'b1;
    inv_exp = ~out_or;
    chk("ready", 32'(req_ready), 32'(er));
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("inv",   32'(out_inv),   32'(inv_exp));
    chk("cnt",   32'(done_count), 32'(m_cnt));
    if (m_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("or", 32'(out_or), 32'(e[W+IDW-1:IDW]));
        chk("id", 32'(out_id), 32'(e[IDW-1:0]));
      end
      m_cnt = m_cnt + 8'd1;
    end
    if (gi >= 0) begin
      o = req_a[gi*W +: W] | req_b[gi*W +: W];
      sb.push_back({o, IDW'(gi)});
      m_last  = gi;
      m_valid = 1'b1;
    end else if (out_ready) m_valid = 1'b0;
    last_gi = gi;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    ASYNCRESET = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_or",    32'(out_or),     32'd0);
    chk("rst_inv",   32'(out_inv),    32'({W{1'b1}}));
    chk("rst_id",    32'(out_id),     32'd0);
    chk("rst_cnt",   32'(done_count), 32'd0);
    chk("rst_ready", 32'(req_ready),  32'd0);
    m_valid = 1'b0;
    m_last  = N - 1;
    m_cnt   = '0;
    sb.delete();
    @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;
  endtask

  initial begin
    ASYNCRESET = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    out_ready  = 1'b0;
    do_reset();

    // Single op from requester 0: 01|10 -> 11.
    req_valid = 4'b0001; req_a = 8'h01; req_b = 8'h02; out_ready = 1'b1;
    step();
    chk("s1_grant", 32'(last_gi), 32'd0);
    req_valid = '0;
    chk("s1_or",  32'(out_or),  32'h3);
    chk("s1_inv", 32'(out_inv), 32'h0);
    step();
    chk("s1_cnt", 32'(done_count), 32'd1);

    // All requesting, full throughput: grants 0,1,2,3,0,1,2,3.
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_a = 8'($urandom); req_b = 8'($urandom);
      step();
      chk("rr_seq", 32'(last_gi), 32'(k % N));
    end
    req_valid = '0;
    step();
    chk("rr_cnt8", 32'(done_count), 32'd8);

    // Stall with a pending result of 01; requester 1 must wait.
    do_reset();
    req_valid = 4'b0001; req_a = 8'h01; req_b = 8'h00; out_ready = 1'b0;
    step();
    req_valid = 4'b0010; req_a = 8'h0C; req_b = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_or",    32'(out_or),    32'h1);
      chk("stall_id",    32'(out_id),    32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("stall_release", 32'(last_gi), 32'd1);
    req_valid = '0;
    chk("stall_new_or", 32'(out_or), 32'h3);
    step();

    // Wrap: last_grant=3 after reset, 1001 -> 0 then 3.
    do_reset();
    req_valid = 4'b1001; req_a = 8'h81; req_b = 8'h42; out_ready = 1'b1;
    step();
    chk("wrap_first", 32'(last_gi), 32'd0);
    step();
    chk("wrap_second", 32'(last_gi), 32'd3);
    req_valid = '0;
    step();

    // Reset pulsed mid-cycle with a result pending and done_count=5.
    do_reset();
    req_valid = 4'b0001; req_a = 8'h01; req_b = 8'h00; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    chk("pre_rst_cnt",   32'(done_count), 32'd5);
    chk("pre_rst_valid", 32'(out_valid),  32'd1);
    #2;
    do_reset();
    req_valid = '0;
    step();

    // 256 consumed results wrap done_count to 0.
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      req_a = 8'($urandom); req_b = 8'($urandom);
      step();
    end
    req_valid = '0;
    step();
    chk("cnt_wrap", 32'(done_count), 32'd0);

    // Random traffic with backpressure.
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom);
      req_a     = 8'($urandom);
      req_b     = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0; out_ready = 1'b1;
    step();
    step();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shared_or_arbiter.md
SHARED_OR_ARBITER -- requirements
Module: shared_or_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the OR unit (2..8).
REQ-002 SHALL have parameter WIDTH, default 2, operand width of the shared OR unit.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port ASYNCRESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  bit i = requester i presents an operation.
REQ-006 SHALL have port req_a  input  N_REQ*WIDTH  operand A; slice i belongs to requester i.
REQ-007 SHALL have port req_b  input  N_REQ*WIDTH  operand B; slice i belongs to requester i.
REQ-008 SHALL have port req_ready  output  N_REQ  bit i = requester i is granted this cycle.
REQ-009 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-011 SHALL have port out_or  output  WIDTH  registered A|B of the granted operation.
REQ-012 SHALL have port out_inv  output  WIDTH  bitwise complement of out_or.
REQ-013 SHALL have port out_id  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-014 SHALL have port done_count  output  8  count of results consumed (out_valid & out_ready).

Function
REQ-015 SHALL contain exactly one WIDTH-bit bitwise OR unit, shared among all requesters.
REQ-016 SHALL define slot_free = !out_valid | out_ready (combinational).
REQ-017 SHALL assert at most one req_ready bit per cycle; none when slot_free=0 or no req_valid bit is set.
REQ-018 SHALL pick the grant round-robin: first i with req_valid[i]=1 scanning from (last_grant+1) mod N_REQ upward, with wrap-around.
REQ-019 SHALL update last_grant to the granted index only on a transfer (req_valid[i] & req_ready[i]).
REQ-020 SHALL let req_ready depend combinationally on req_valid, out_valid, out_ready and last_grant only.
REQ-021 SHALL, on a transfer in cycle t, load out_or = a_i|b_i, out_id = i and set out_valid=1 at edge t+1 (latency 1).
REQ-022 SHALL drive out_inv = ~out_or at all times, including reset.
REQ-023 SHALL hold out_or, out_id, out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL clear out_valid on out_valid & out_ready with no new transfer; on simultaneous consume and new transfer, load the new result with out_valid remaining 1 (full throughput, one op/cycle).
REQ-025 SHALL increment done_count by 1 on each out_valid & out_ready, wrapping 255 -> 0.
REQ-026 SHALL tolerate req_valid deasserting without a grant; no state change results.
REQ-027 SHALL ignore req_a/req_b of ungranted requesters.
REQ-028 SHALL treat the two states EMPTY (out_valid=0) and FULL (out_valid=1): EMPTY->FULL on transfer; FULL->EMPTY on consume without transfer; FULL->FULL on consume+transfer or on stall.

Reset
REQ-029 SHALL, while ASYNCRESET=1, immediately force out_valid=0, out_or=0, out_inv=all ones, out_id=0, done_count=0, last_grant=N_REQ-1, req_ready=0.
REQ-030 SHALL discard any pending result when reset asserts mid-operation; no partial update after release.
REQ-031 SHALL resume granting at the first rising CLK edge after ASYNCRESET deasserts, requester 0 first in priority.

Verification
REQ-032 SHALL cover: reset release, req_valid=0001, a0=01, b0=10, out_ready=1 -> req_ready=0001 in cycle 0; next cycle out_valid=1, out_or=11, out_inv=00, out_id=0, then done_count=1.
REQ-033 SHALL cover: req_valid=1111 held, out_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; one result per cycle; done_count=8.
REQ-034 SHALL cover: out_valid=1 with out_or=01, out_ready=0 for 3 cycles, req_valid=0010 -> req_ready=0000, outputs stable; out_ready=1 -> req_ready=0010 same cycle, new result next cycle.
REQ-035 SHALL cover: last_grant=3, req_valid=1001 -> requester 0 granted (wrap), then requester 3.
REQ-036 SHALL cover: ASYNCRESET pulsed between clock edges while out_valid=1, done_count=5 -> out_valid=0, done_count=0, out_inv=11 without waiting for an edge.
REQ-037 SHALL cover: 256 consumed results -> done_count wraps to 0.
